uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: oversampled start-bit validation, LSB-first data recovery,
// registered one-cycle valid / framing-error strobes, resync only after the line idles high.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    // state     | meaning
    // IDLE      | line idle, waiting for a low sample
    // START     | counting to mid start bit to confirm it is not a glitch
    // DATA      | sampling one data bit per bit period, LSB first
    // STOP      | sampling the stop bit at mid bit
    // WAIT_IDLE | stop bit was low; hold off until the line returns high

    localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [CW-1:0] MID_TC   = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] BIT_TC   = CW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 rx_m;
    logic                 rx_s;
    logic [CW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 mid_tc;
    logic                 bit_tc;
    logic                 valid_set;
    logic                 error_set;

    assign mid_tc = (tick_cnt == MID_TC);
    assign bit_tc = (tick_cnt == BIT_TC);

    // Both synchroniser flops reset high so reset never looks like a start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (sample_tick) begin
            case (state)
                IDLE: begin
                    if (!rx_s) state_next = START;
                end
                START: begin
                    if (mid_tc) state_next = rx_s ? IDLE : DATA;
                end
                DATA: begin
                    if (bit_tc && (bit_idx == LAST_BIT)) state_next = STOP;
                end
                STOP: begin
                    if (bit_tc) state_next = rx_s ? IDLE : WAIT_IDLE;
                end
                WAIT_IDLE: begin
                    if (rx_s) state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        valid_set = 1'b0;
        error_set = 1'b0;
        busy      = (state != IDLE);
        if (sample_tick && (state == STOP) && bit_tc) begin
            valid_set = rx_s;
            error_set = !rx_s;
        end
    end

    // Counters and the data path only move on sample_tick; strobes default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            data_valid  <= valid_set;
            frame_error <= error_set;
            if (valid_set) begin
                data_out <= shift_reg;
            end
            if (sample_tick) begin
                case (state)
                    IDLE: begin
                        tick_cnt <= '0;
                    end
                    START: begin
                        if (mid_tc) begin
                            tick_cnt <= '0;
                            bit_idx  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    DATA: begin
                        if (bit_tc) begin
                            tick_cnt           <= '0;
                            shift_reg[bit_idx] <= rx_s;
                            bit_idx            <= (bit_idx == LAST_BIT) ? '0 : bit_idx + BW'(1);
                        end else begin
                            tick_cnt <= tick_cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        tick_cnt <= bit_tc ? '0 : tick_cnt + CW'(1);
                    end
                    default: begin
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: an ideal serial source drives 16-tick bits, and a negedge
// monitor records strobes so each scenario task can compare against hand-computed bytes.
module tb_uart_rx;

    localparam int DATA_BITS  = 8;
    localparam int OVERSAMPLE = 16;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 rx = 1'b1;
    logic [1:0]           tick_div = 2'd0;
    logic                 sample_tick;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;

    int n_vec  = 0;
    int n_fail = 0;

    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         both_cnt  = 0;
    logic [7:0] rx_q[$];

    uart_rx #(.DATA_BITS(DATA_BITS), .OVERSAMPLE(OVERSAMPLE)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_tick (sample_tick),
        .rx          (rx),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .frame_error (frame_error),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // One sample_tick every fourth clock, independent of reset.
    always @(posedge clk) tick_div <= tick_div + 2'd1;
    assign sample_tick = (tick_div == 2'd3);

    always @(negedge clk) begin
        if (data_valid) begin
            rx_q.push_back(data_out);
            valid_cnt++;
        end
        if (frame_error) err_cnt++;
        if (data_valid && frame_error) both_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_ticks(input int n);
        repeat (n) begin
            do @(negedge clk); while (!sample_tick);
        end
    endtask

    // Ideal transmitter: a baud step every OVERSAMPLE sample ticks; rx is left at the stop level.
    task automatic send_frame(input logic [7:0] b, input logic stop_val);
        rx = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int i = 0; i < DATA_BITS; i++) begin
            rx = b[i];
            wait_ticks(OVERSAMPLE);
        end
        rx = stop_val;
        wait_ticks(OVERSAMPLE);
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
        n_vec++;
        if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
        n_vec++;
        if (frame_error !== 1'b0) begin n_fail++; $display("FAIL reset_frame_error: got %b expected 0", frame_error); end
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        reset = 1'b0;
        wait_ticks(4);
    endtask

    task automatic test_frame_a5;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        rx = 1'b0;
        wait_ticks(24);
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL a5_busy_mid: got %b expected 1", busy); end
        rx = 1'b1;
        wait_ticks(8);
        send_frame_tail(8'hA5);
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL a5_busy_end: got %b expected 0", busy); end
        n_vec++;
        if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL a5_valid_count: got %0d expected 1", valid_cnt - v0); end
        n_vec++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL a5_data_out: got %h expected a5", data_out); end
        n_vec++;
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL a5_frame_error: got %0d expected 0", err_cnt - e0); end
        wait_ticks(4);
    endtask

    // Remaining bits of an 0xA5 frame whose start bit and bit 0 (=1) were already driven.
    task automatic send_frame_tail(input logic [7:0] b);
        for (int i = 1; i < DATA_BITS; i++) begin
            rx = b[i];
            wait_ticks(OVERSAMPLE);
        end
        rx = 1'b1;
        wait_ticks(OVERSAMPLE);
    endtask

    task automatic test_glitch;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        rx = 1'b0;
        wait_ticks(3);
        rx = 1'b1;
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        wait_ticks(16);
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_idle: got %b expected 0", busy); end
        n_vec++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL glitch_strobes: got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0));
        end
        n_vec++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL glitch_data_out: got %h expected a5", data_out); end
    endtask

    task automatic test_break;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b0);
        wait_ticks(5 * OVERSAMPLE);
        n_vec++;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL break_frame_error_count: got %0d expected 1", err_cnt - e0); end
        n_vec++;
        if (valid_cnt - v0 !== 0) begin n_fail++; $display("FAIL break_valid_count: got %0d expected 0", valid_cnt - v0); end
        n_vec++;
        if (data_out !== 8'hA5) begin n_fail++; $display("FAIL break_data_out: got %h expected a5", data_out); end
        n_vec++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_wait: got %b expected 1", busy); end
        rx = 1'b1;
        wait_ticks(4);
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_idle: got %b expected 0", busy); end
        send_frame(8'h5A, 1'b1);
        n_vec++;
        if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL break_next_valid_count: got %0d expected 1", valid_cnt - v0); end
        n_vec++;
        if (data_out !== 8'h5A) begin n_fail++; $display("FAIL break_next_data: got %h expected 5a", data_out); end
        n_vec++;
        if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL break_next_error_count: got %0d expected 1", err_cnt - e0); end
        wait_ticks(4);
    endtask

    task automatic test_lsb_first;
        int v0;
        v0 = valid_cnt;
        send_frame(8'h01, 1'b1);
        wait_ticks(2);
        send_frame(8'h35, 1'b1);
        wait_ticks(2);
        n_vec++;
        if (valid_cnt - v0 !== 2) begin
            n_fail++; $display("FAIL lsb_valid_count: got %0d expected 2", valid_cnt - v0);
        end else begin
            n_vec++;
            if (rx_q[v0] !== 8'h01) begin n_fail++; $display("FAIL lsb_byte0: got %h expected 01", rx_q[v0]); end
            n_vec++;
            if (rx_q[v0 + 1] !== 8'h35) begin n_fail++; $display("FAIL lsb_byte1: got %h expected 35", rx_q[v0 + 1]); end
        end
    endtask

    task automatic test_back_to_back;
        int v0, e0;
        v0 = valid_cnt; e0 = err_cnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        n_vec++;
        if (valid_cnt - v0 !== 2) begin
            n_fail++; $display("FAIL b2b_valid_count: got %0d expected 2", valid_cnt - v0);
        end else begin
            n_vec++;
            if (rx_q[v0] !== 8'h00) begin n_fail++; $display("FAIL b2b_byte0: got %h expected 00", rx_q[v0]); end
            n_vec++;
            if (rx_q[v0 + 1] !== 8'hFF) begin n_fail++; $display("FAIL b2b_byte1: got %h expected ff", rx_q[v0 + 1]); end
        end
        n_vec++;
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL b2b_frame_error: got %0d expected 0", err_cnt - e0); end
        wait_ticks(4);
    endtask

    task automatic test_reset_midframe;
        int v0, e0;
        logic [7:0] b;
        v0 = valid_cnt; e0 = err_cnt;
        b = 8'h3C;
        rx = 1'b0;
        wait_ticks(OVERSAMPLE);
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            wait_ticks(OVERSAMPLE);
        end
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        n_vec++;
        if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data_out: got %h expected 00", data_out); end
        n_vec++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        wait_ticks(3 * OVERSAMPLE);
        n_vec++;
        if ((valid_cnt - v0) + (err_cnt - e0) !== 0) begin
            n_fail++; $display("FAIL rst_mid_strobes: got %0d expected 0", (valid_cnt - v0) + (err_cnt - e0));
        end
        send_frame(8'h3C, 1'b1);
        n_vec++;
        if (valid_cnt - v0 !== 1) begin n_fail++; $display("FAIL rst_mid_next_count: got %0d expected 1", valid_cnt - v0); end
        n_vec++;
        if (data_out !== 8'h3C) begin n_fail++; $display("FAIL rst_mid_next_data: got %h expected 3c", data_out); end
        wait_ticks(4);
    endtask

    task automatic test_loopback;
        int v0, e0;
        logic [7:0] exp_bytes[4];
        v0 = valid_cnt; e0 = err_cnt;
        exp_bytes = '{8'h00, 8'hFF, 8'h81, 8'h7E};
        for (int i = 0; i < 4; i++) send_frame(exp_bytes[i], 1'b1);
        wait_ticks(4);
        n_vec++;
        if (valid_cnt - v0 !== 4) begin
            n_fail++; $display("FAIL loop_valid_count: got %0d expected 4", valid_cnt - v0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                n_vec++;
                if (rx_q[v0 + i] !== exp_bytes[i]) begin
                    n_fail++; $display("FAIL loop_byte%0d: got %h expected %h", i, rx_q[v0 + i], exp_bytes[i]);
                end
            end
        end
        n_vec++;
        if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL loop_frame_error: got %0d expected 0", err_cnt - e0); end
        n_vec++;
        if (both_cnt !== 0) begin n_fail++; $display("FAIL strobe_overlap: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_break();
        test_lsb_first();
        test_back_to_back();
        test_reset_midframe();
        test_loopback();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
